// File: rtl/merge_pkg.sv
// Shared types for the N-way merge: operating mode and FSM state encodings.
package merge_pkg;

  typedef enum logic {
    MERGE_STEERED = 1'b0,
    MERGE_RR      = 1'b1
  } merge_mode_e;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_DATA = 1'b1
  } merge_state_e;

endpackage

// File: rtl/merge_fifo.sv
// Small output FIFO with registered storage; head is read straight from the entry at rd_ptr.
module merge_fifo #(
  parameter int unsigned W     = 35,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/merge_n_sync.sv
// N-way valid/ready merge: steered by a select channel or round-robin arbitrated,
// feeding a small output FIFO; each token is tagged with its source index.
module merge_n_sync
  import merge_pkg::*;
#(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic               sel_valid,
  output logic               sel_ready,
  input  logic [SEL_W-1:0]   sel_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_src,
  output logic               err_sel
);

  localparam int unsigned FW = WIDTH + SEL_W;

  merge_state_e     state_q, state_d;
  merge_mode_e      mode_e;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             err_d;
  logic             push;
  logic [SEL_W-1:0] push_src;
  logic [WIDTH-1:0] push_word;
  logic             full;
  logic             empty;
  logic [FW-1:0]    head;
  logic [WIDTH-1:0] in_word [N];
  logic             grant_found;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W:0]   cand;

  assign mode_e = merge_mode_e'(mode);

  for (genvar g = 0; g < int'(N); g++) begin : g_unpack
    assign in_word[g] = in_data[g*WIDTH +: WIDTH];
  end

  // Round-robin search: first valid input at or after rr_ptr, modulo N.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
      if (cand >= (SEL_W+1)'(N)) cand = cand - (SEL_W+1)'(N);
      if (!grant_found && in_valid[cand[SEL_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[SEL_W-1:0];
      end
    end
  end

  // Next-state and handshake outputs; readies are forced low while in reset.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rr_ptr_d  = rr_ptr_q;
    err_d     = 1'b0;
    sel_ready = 1'b0;
    in_ready  = '0;
    push      = 1'b0;
    push_src  = idx_q;
    push_word = in_word[idx_q];
    if (rst_n) begin
      case (state_q)
        ST_IDLE: begin
          if (mode_e == MERGE_STEERED) begin
            sel_ready = 1'b1;
            if (sel_valid) begin
              if ({1'b0, sel_data} < (SEL_W+1)'(N)) begin
                idx_d   = sel_data;
                state_d = ST_WAIT_DATA;
              end else begin
                err_d = 1'b1;
              end
            end
          end else if (!full && grant_found) begin
            in_ready[grant_idx] = 1'b1;
            push      = 1'b1;
            push_src  = grant_idx;
            push_word = in_word[grant_idx];
            rr_ptr_d  = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + SEL_W'(1);
          end
        end
        ST_WAIT_DATA: begin
          if (!full) begin
            in_ready[idx_q] = 1'b1;
            if (in_valid[idx_q]) begin
              push    = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      err_sel  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      err_sel  <= err_d;
    end
  end

  merge_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({push_src, push_word}),
    .pop       (out_ready),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  assign out_valid = !empty;
  assign out_src   = head[FW-1 -: SEL_W];
  assign out_data  = head[WIDTH-1:0];

endmodule

// File: tb/tb_merge_n_sync.sv
// Directed bench for merge_n_sync; N=5 so that select values 5..7 are out of range.
module tb_merge_n_sync;

  localparam int unsigned WIDTH = 33;
  localparam int unsigned N     = 5;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned SEL_W = $clog2(N);

  logic               clk;
  logic               rst_n;
  logic               mode;
  logic               sel_valid;
  logic               sel_ready;
  logic [SEL_W-1:0]   sel_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_src;
  logic               err_sel;

  int errors = 0;
  int checks = 0;

  merge_n_sync #(.WIDTH(WIDTH), .N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel_valid (sel_valid),
    .sel_ready (sel_ready),
    .sel_data  (sel_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .err_sel   (err_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel_data = '0;
    in_valid = '0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; mode = 1'b1; in_valid = '1; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h exp 0", out_data); end
    checks++; if (out_src !== '0) begin errors++; $display("FAIL reset_out_src: got %0d exp 0", out_src); end
    checks++; if (in_ready !== '0) begin errors++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
    checks++; if (sel_ready !== 1'b0) begin errors++; $display("FAIL reset_sel_ready: got %b exp 0", sel_ready); end
    checks++; if (err_sel !== 1'b0) begin errors++; $display("FAIL reset_err_sel: got %b exp 0", err_sel); end
    do_reset();
    checks++; if (sel_ready !== 1'b1) begin errors++; $display("FAIL reset_idle_sel_ready: got %b exp 1", sel_ready); end
  endtask

  task automatic test_steered();
    logic [SEL_W-1:0] sels [3];
    logic [N-1:0]     exp_rdy;
    sels[0] = 3'd2; sels[1] = 3'd0; sels[2] = 3'd3;
    mode = 1'b0; out_ready = 1'b1; in_valid = '1;
    for (int k = 0; k < 3; k++) begin
      sel_valid = 1'b1; sel_data = sels[k];
      #1;
      checks++; if (sel_ready !== 1'b1) begin errors++; $display("FAIL steer_sel_ready[%0d]: got %b exp 1", k, sel_ready); end
      checks++; if (in_ready !== '0) begin errors++; $display("FAIL steer_idle_in_ready[%0d]: got %b exp 0", k, in_ready); end
      tick();
      sel_valid = 1'b0;
      #1;
      exp_rdy = N'(1) << sels[k];
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL steer_in_ready[%0d]: got %b exp %b", k, in_ready, exp_rdy); end
      checks++; if (sel_ready !== 1'b0) begin errors++; $display("FAIL steer_wait_sel_ready[%0d]: got %b exp 0", k, sel_ready); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL steer_out_valid[%0d]: got %b exp 1", k, out_valid); end
      checks++; if (out_data !== WIDTH'(32'hA0 + 32'(sels[k]))) begin errors++; $display("FAIL steer_out_data[%0d]: got %h exp %h", k, out_data, 32'hA0 + 32'(sels[k])); end
      checks++; if (out_src !== sels[k]) begin errors++; $display("FAIL steer_out_src[%0d]: got %0d exp %0d", k, out_src, sels[k]); end
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL steer_drain: got %b exp 0", out_valid); end
    in_valid = '0;
  endtask

  task automatic test_err_sel();
    mode = 1'b0; in_valid = '1; out_ready = 1'b1;
    sel_valid = 1'b1; sel_data = 3'd5;
    #1;
    checks++; if (sel_ready !== 1'b1) begin errors++; $display("FAIL err_sel_ready: got %b exp 1", sel_ready); end
    tick();
    sel_valid = 1'b0;
    #1;
    checks++; if (err_sel !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b exp 1", err_sel); end
    checks++; if (in_ready !== '0) begin errors++; $display("FAIL err_in_ready: got %b exp 0", in_ready); end
    checks++; if (sel_ready !== 1'b1) begin errors++; $display("FAIL err_stay_idle: got %b exp 1", sel_ready); end
    tick();
    checks++; if (err_sel !== 1'b0) begin errors++; $display("FAIL err_pulse_end: got %b exp 0", err_sel); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL err_no_token: got %b exp 0", out_valid); end
    in_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_rdy;
    do_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = 5'b01111;
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_rdy = N'(1) << (k % 4);
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rr_in_ready[%0d]: got %b exp %b", k, in_ready, exp_rdy); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_out_valid[%0d]: got %b exp 1", k, out_valid); end
      checks++; if (out_src !== SEL_W'(k % 4)) begin errors++; $display("FAIL rr_out_src[%0d]: got %0d exp %0d", k, out_src, k % 4); end
      checks++; if (out_data !== WIDTH'(32'hA0 + 32'(k % 4))) begin errors++; $display("FAIL rr_out_data[%0d]: got %h exp %h", k, out_data, 32'hA0 + 32'(k % 4)); end
    end
    in_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b1; out_ready = 1'b0; in_valid = 5'b01111;
    #1;
    checks++; if (in_ready !== 5'b00001) begin errors++; $display("FAIL bp_first_grant: got %b exp 00001", in_ready); end
    tick();
    checks++; if (out_src !== 3'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_head0: got src %0d valid %b exp 0/1", out_src, out_valid); end
    checks++; if (in_ready !== 5'b00010) begin errors++; $display("FAIL bp_second_grant: got %b exp 00010", in_ready); end
    tick();
    checks++; if (in_ready !== '0) begin errors++; $display("FAIL bp_full: got %b exp 0", in_ready); end
    tick();
    checks++; if (in_ready !== '0) begin errors++; $display("FAIL bp_full_hold: got %b exp 0", in_ready); end
    checks++; if (out_data !== WIDTH'(32'hA0) || out_src !== 3'd0) begin errors++; $display("FAIL bp_head_stable: got %h/%0d exp a0/0", out_data, out_src); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== '0) begin errors++; $display("FAIL bp_no_comb_path: got %b exp 0", in_ready); end
    tick();
    out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 5'b00100) begin errors++; $display("FAIL bp_after_pop: got %b exp 00100", in_ready); end
    checks++; if (out_src !== 3'd1 || out_data !== WIDTH'(32'hA1)) begin errors++; $display("FAIL bp_new_head: got %h/%0d exp a1/1", out_data, out_src); end
    tick();
    checks++; if (in_ready !== '0) begin errors++; $display("FAIL bp_refull: got %b exp 0", in_ready); end
    tick();
    checks++; if (in_ready !== '0 || out_src !== 3'd1) begin errors++; $display("FAIL bp_one_only: got %b/%0d exp 0/1", in_ready, out_src); end
    in_valid = '0;
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 1'b0; out_ready = 1'b1; in_valid = '0;
    sel_valid = 1'b1; sel_data = 3'd1;
    tick();
    sel_valid = 1'b0; mode = 1'b1;
    #1;
    checks++; if (in_ready !== 5'b00010) begin errors++; $display("FAIL ms_wait_ready: got %b exp 00010", in_ready); end
    checks++; if (sel_ready !== 1'b0) begin errors++; $display("FAIL ms_sel_ready: got %b exp 0", sel_ready); end
    in_valid = 5'b01111;
    #1;
    checks++; if (in_ready !== 5'b00010) begin errors++; $display("FAIL ms_pending_first: got %b exp 00010", in_ready); end
    tick();
    checks++; if (out_src !== 3'd1 || out_data !== WIDTH'(32'hA1)) begin errors++; $display("FAIL ms_token1: got %h/%0d exp a1/1", out_data, out_src); end
    checks++; if (in_ready !== 5'b00001) begin errors++; $display("FAIL ms_rr_start: got %b exp 00001", in_ready); end
    tick();
    checks++; if (out_src !== 3'd0) begin errors++; $display("FAIL ms_rr_src0: got %0d exp 0", out_src); end
    checks++; if (in_ready !== 5'b00010) begin errors++; $display("FAIL ms_rr_next: got %b exp 00010", in_ready); end
    in_valid = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    mode = 1'b0; out_ready = 1'b0; in_valid = 5'b01111;
    for (int k = 0; k < 2; k++) begin
      sel_valid = 1'b1; sel_data = SEL_W'(k);
      tick();
      sel_valid = 1'b0;
      tick();
    end
    sel_valid = 1'b1; sel_data = 3'd2;
    tick();
    sel_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || in_ready !== '0 || sel_ready !== 1'b0) begin errors++; $display("FAIL ar_pre: got v%b r%b s%b exp 1/0/0", out_valid, in_ready, sel_ready); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid: got %b exp 0", out_valid); end
    checks++; if (in_ready !== '0 || sel_ready !== 1'b0) begin errors++; $display("FAIL ar_readies: got %b/%b exp 0/0", in_ready, sel_ready); end
    checks++; if (out_data !== '0 || out_src !== '0) begin errors++; $display("FAIL ar_head: got %h/%0d exp 0/0", out_data, out_src); end
    #1;
    rst_n = 1'b1;
    #1;
    checks++; if (sel_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL ar_release: got s%b v%b exp 1/0", sel_ready, out_valid); end
    sel_valid = 1'b1; sel_data = 3'd3;
    tick();
    sel_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 5'b01000) begin errors++; $display("FAIL ar_new_sel: got %b exp 01000", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_src !== 3'd3) begin errors++; $display("FAIL ar_new_token: got v%b src %0d exp 1/3", out_valid, out_src); end
    in_valid = '0;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel_data = '0;
    in_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < int'(N); i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(32'hA0 + 32'(i));
    test_reset();
    test_steered();
    test_err_sel();
    test_round_robin();
    test_backpressure();
    test_mode_switch();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
